// File: rtl/cva6_pma_region_unit.sv
// Runtime-programmable PMA table: NrRules base/length/attr entries, lowest-index match wins.
// Lookup latency 1 cycle through a single output register; config responses return next cycle.
module cva6_pma_region_unit #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned NrRules   = 8,
    parameter logic [NrRules*AddrWidth-1:0] RstBase = (NrRules*AddrWidth)'({
        AddrWidth'(0), AddrWidth'(64'h1_0000), AddrWidth'(64'h8000_0000)}),
    parameter logic [NrRules*AddrWidth-1:0] RstLength = (NrRules*AddrWidth)'({
        AddrWidth'(64'h1000), AddrWidth'(64'h1_0000), AddrWidth'(64'h4000_0000)}),
    parameter logic [NrRules*4-1:0] RstAttr = (NrRules*4)'({4'h1, 4'h5, 4'h7})
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [3:0]           cfg_idx_i,
    input  logic [1:0]           cfg_sel_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_rvalid_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 lu_valid_i,
    output logic                 lu_ready_o,
    input  logic [AddrWidth-1:0] lu_addr_i,
    output logic                 lu_valid_o,
    input  logic                 lu_ready_i,
    output logic                 lu_hit_o,
    output logic [3:0]           lu_rule_o,
    output logic                 lu_exec_o,
    output logic                 lu_cached_o,
    output logic                 lu_idem_o,
    output logic [31:0]          miss_cnt_o
);

    logic [AddrWidth-1:0] base_q [NrRules];
    logic [AddrWidth-1:0] len_q  [NrRules];
    logic [3:0]           attr_q [NrRules];

    logic [AddrWidth-1:0] sel_base, sel_len;
    logic [3:0]           sel_attr;
    logic                 cfg_ok, cfg_err_d, cfg_wr;
    logic [AddrWidth-1:0] cfg_rdata_d;

    logic                 cfg_rvalid_q, cfg_err_q;
    logic [AddrWidth-1:0] cfg_rdata_q;

    logic                 m_hit;
    logic [3:0]           m_rule;
    logic [2:0]           m_attr;
    logic                 lu_acc;

    logic                 lu_valid_q, lu_valid_d, lu_hit_q;
    logic [3:0]           lu_rule_q;
    logic [2:0]           lu_attr_q;
    logic [31:0]          miss_cnt_q, miss_cnt_d;

    always_comb begin
        sel_base = '0;
        sel_len  = '0;
        sel_attr = '0;
        for (int i = 0; i < int'(NrRules); i++) begin
            if (cfg_idx_i == 4'(i)) begin
                sel_base = base_q[i];
                sel_len  = len_q[i];
                sel_attr = attr_q[i];
            end
        end
    end

    // Locked entries reject writes of any field; reads stay legal.
    always_comb begin
        cfg_ok      = ({1'b0, cfg_idx_i} < 5'(NrRules)) && (cfg_sel_i != 2'd3);
        cfg_err_d   = !cfg_ok || (cfg_we_i && sel_attr[3]);
        cfg_wr      = cfg_req_i && cfg_we_i && !cfg_err_d;
        cfg_rdata_d = '0;
        if (cfg_ok && !cfg_we_i) begin
            case (cfg_sel_i)
                2'd0:    cfg_rdata_d = sel_base;
                2'd1:    cfg_rdata_d = sel_len;
                2'd2:    cfg_rdata_d = AddrWidth'(sel_attr);
                default: cfg_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrRules); i++) begin
                base_q[i] <= RstBase[i*AddrWidth +: AddrWidth];
                len_q[i]  <= RstLength[i*AddrWidth +: AddrWidth];
                attr_q[i] <= {1'b0, RstAttr[i*4 +: 3]};
            end
        end else if (cfg_wr) begin
            for (int i = 0; i < int'(NrRules); i++) begin
                if (cfg_idx_i == 4'(i)) begin
                    case (cfg_sel_i)
                        2'd0:    base_q[i] <= cfg_wdata_i;
                        2'd1:    len_q[i]  <= cfg_wdata_i;
                        2'd2:    attr_q[i] <= cfg_wdata_i[3:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rvalid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            cfg_rdata_q  <= '0;
        end else begin
            cfg_rvalid_q <= cfg_req_i;
            cfg_err_q    <= cfg_req_i && cfg_err_d;
            cfg_rdata_q  <= cfg_req_i ? cfg_rdata_d : '0;
        end
    end

    // End is taken one bit wider so a region reaching 2^AddrWidth covers the top address.
    always_comb begin
        m_hit  = 1'b0;
        m_rule = '0;
        m_attr = '0;
        for (int i = int'(NrRules) - 1; i >= 0; i--) begin
            if ((len_q[i] != '0) && (lu_addr_i >= base_q[i]) &&
                ({1'b0, lu_addr_i} < ({1'b0, base_q[i]} + {1'b0, len_q[i]}))) begin
                m_hit  = 1'b1;
                m_rule = 4'(i);
                m_attr = attr_q[i][2:0];
            end
        end
    end

    assign lu_ready_o = !lu_valid_q || lu_ready_i;
    assign lu_acc     = lu_valid_i && lu_ready_o;

    always_comb begin
        lu_valid_d = lu_valid_q;
        miss_cnt_d = miss_cnt_q;
        if (lu_acc) begin
            lu_valid_d = 1'b1;
            if (!m_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end else if (lu_ready_i) begin
            lu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lu_valid_q <= 1'b0;
            lu_hit_q   <= 1'b0;
            lu_rule_q  <= '0;
            lu_attr_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            lu_valid_q <= lu_valid_d;
            miss_cnt_q <= miss_cnt_d;
            if (lu_acc) begin
                lu_hit_q  <= m_hit;
                lu_rule_q <= m_rule;
                lu_attr_q <= m_attr;
            end
        end
    end

    assign cfg_rvalid_o = cfg_rvalid_q;
    assign cfg_rdata_o  = cfg_rdata_q;
    assign cfg_err_o    = cfg_err_q;
    assign lu_valid_o   = lu_valid_q;
    assign lu_hit_o     = lu_hit_q;
    assign lu_rule_o    = lu_rule_q;
    assign lu_exec_o    = lu_attr_q[0];
    assign lu_cached_o  = lu_attr_q[1];
    assign lu_idem_o    = lu_attr_q[2];
    assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: doc/cva6_pma_region_unit.md
Name: cva6_pma_region_unit

Overview:
- Runtime-programmable physical memory attribute (PMA) unit.
- Replaces the static execute, cached and idempotent region rules with a parametrised table of NrRules entries. Each entry has a base, a length, an attribute nibble and a lock bit, and is written through a simple config port.
- Sits beside the MMU/PMP path and serves registered, handshaked lookups to fetch and LSU.

Parameters:
- AddrWidth, 64, address and register width.
- NrRules, 8, number of region entries; legal range 1..16.
- RstBase, {0x8000_0000, 0x1_0000, 0x0, 0...}, flat NrRules*AddrWidth reset bases; entry 0 occupies the LSBs.
- RstLength, {0x4000_0000, 0x10000, 0x1000, 0...}, flat reset lengths.
- RstAttr, {0x7, 0x5, 0x1, 0...}, flat NrRules*4 reset attributes.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_req_i  in  1  config access request.
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_idx_i  in  4  rule index.
- cfg_sel_i  in  2  field select: 0 = base, 1 = length, 2 = attr, 3 = reserved.
- cfg_wdata_i  in  AddrWidth  write data.
- cfg_rvalid_o  out  1  config response valid.
- cfg_rdata_o  out  AddrWidth  read data.
- cfg_err_o  out  1  config error (qualified by cfg_rvalid_o).
- lu_valid_i  in  1  lookup request valid.
- lu_ready_o  out  1  lookup request ready.
- lu_addr_i  in  AddrWidth  lookup physical address.
- lu_valid_o  out  1  lookup result valid.
- lu_ready_i  in  1  result consumer ready.
- lu_hit_o  out  1  a rule matched.
- lu_rule_o  out  4  index of the matching rule.
- lu_exec_o  out  1  executable.
- lu_cached_o  out  1  cacheable.
- lu_idem_o  out  1  idempotent.
- miss_cnt_o  out  32  saturating lookup-miss counter.

Behaviour:
- Reset (async assert, sync release):
  - Table loads RstBase, RstLength and RstAttr.
  - Lock bits clear.
  - lu_valid_o, cfg_rvalid_o, cfg_err_o, lu_hit_o, lu_exec_o, lu_cached_o, lu_idem_o are 0.
  - cfg_rdata_o, lu_rule_o and miss_cnt_o are 0.
- Attr nibble: bit0 = exec, bit1 = cached, bit2 = idempotent, bit3 = lock.
  - Reads return the attr nibble zero-extended.
  - Writes take cfg_wdata_i[3:0].
- Match rule for entry i: base_i <= addr and addr < base_i + length_i.
  - The sum is computed in AddrWidth+1 bits, so a region ending at 2^AddrWidth matches through the top address.
  - length 0 disables the entry.
  - Lowest matching index wins.
- Miss result: hit = 0, rule = 0, exec = cached = idem = 0 (conservative).
- Lookup pipeline: one output register.
  - lu_ready_o = !lu_valid_o || lu_ready_i.
  - An accept (lu_valid_i && lu_ready_o) evaluates the table combinationally from its current contents and registers the result. lu_valid_o rises the next cycle.
  - Latency is 1 cycle; throughput is 1 per cycle while lu_ready_i is high.
  - While lu_valid_o && !lu_ready_i, result outputs hold stable.
  - lu_valid_o falls after a handshake with no new accept.
- Config access: always granted; the response arrives the next cycle with cfg_rvalid_o = 1 for exactly one cycle.
- Errors (no state change, rdata = 0, err = 1): cfg_idx_i >= NrRules, or cfg_sel_i = 3.
- Locked entries: any write to base, length or attr of a locked entry sets err = 1 and changes nothing. Reads are allowed.
- Writing attr with bit3 = 1 sets the lock. The same write's other bits take effect. The lock clears only on reset.
- Simultaneous write and lookup accept in the same cycle: the lookup sees the pre-write value; the write is visible to accepts from the next cycle.
- miss_cnt_o increments by 1 on each accepted lookup that misses and saturates at 0xFFFF_FFFF.
- Reset mid-operation: any pending result and config response are dropped; all outputs return to their reset values.

Test Plan:
1. Reset, then look up 0x8000_1000, 0x1_0004 and 0x0800 -> hit = 1 with rule 0 / exec, cached, idem = 1,1,1; rule 1 / 1,0,1; rule 2 / 1,0,0. Each result arrives 1 cycle after accept.
2. Look up 0xC000_0000 (one past the DRAM end) -> hit = 0, all attributes 0, miss_cnt_o = 1.
3. Write rule 3 base 0x9000_0000, length 0x1000, attr 0xB, then rewrite its base 0x0 -> second write returns err = 1. Lookup 0x9000_0FFF -> rule 3, exec = 1, cached = 1, idem = 0.
4. Back-to-back 4 lookups with lu_ready_i low for 3 cycles after the first -> lu_ready_o low and result held for 3 cycles. No result is lost or duplicated; order is preserved.
5. Same-cycle write of rule 0 length 0 and lookup of 0x8000_0000 -> that lookup still hits rule 0. The next lookup of 0x8000_0000 misses.
6. Config read with idx 12 (NrRules = 8) and with sel 3 -> err = 1, rdata = 0. Rule 7 base 0xFFFF_FFFF_FFFF_F000, length 0x1000 -> lookup of 0xFFFF_FFFF_FFFF_FFFF hits rule 7.
